scarv_cop_pmul_seq: RTL
=======================

SCARV_COP_PMUL_SEQ -- requirements
Module: scarv_cop_pmul_seq

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand width; legal values 32 or 64.
REQ-002 SHALL have parameter BPC, default 1, multiplier bits consumed per cycle; legal values 1 or 2.
REQ-003 SHALL have port g_clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port g_reset, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port req_valid, input, 1, request present.
REQ-006 SHALL have port req_ready, output, 1, block can accept a request.
REQ-007 SHALL have port req_a, input, XLEN, multiplicand lanes.
REQ-008 SHALL have port req_b, input, XLEN, multiplier lanes.
REQ-009 SHALL have port req_pw, input, 3, pack-width code from the shared package.
REQ-010 SHALL have port req_high, input, 1, return the upper w bits of each 2w-bit lane product.
REQ-011 SHALL have port req_ncarry, input, 1, carry-less (GF(2)) multiply.
REQ-012 SHALL have port flush, input, 1, abort the in-flight operation.
REQ-013 SHALL have port rsp_valid, output, 1, result present.
REQ-014 SHALL have port rsp_ready, input, 1, consumer accepts result.
REQ-015 SHALL have port rsp_result, output, XLEN, packed per-lane result.

Function
REQ-016 SHALL derive lane width w from req_pw as XLEN, XLEN/2, XLEN/4, XLEN/8 or XLEN/16; any other code SHALL be treated as w=XLEN.
REQ-017 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-018 SHALL assert req_ready only in IDLE.
REQ-019 SHALL, on req_valid && req_ready, latch all req_* fields, clear the 2*XLEN-bit accumulator, and enter BUSY.
REQ-020 SHALL, in BUSY, on each cycle consume BPC bits of every lane of b, LSB first, and add (or XOR when ncarry) the shifted partial product of a into that lane's 2w-bit accumulator segment.
REQ-021 SHALL block carries at lane-segment boundaries.
REQ-022 SHALL stay in BUSY for exactly w/BPC cycles, then enter DONE.
REQ-023 SHALL assert rsp_valid only in DONE, with rsp_result equal to the low or high w bits of each lane product, placed at the lane position.
REQ-024 SHALL hold rsp_result stable while rsp_valid && !rsp_ready.
REQ-025 SHALL return to IDLE on rsp_valid && rsp_ready; the earliest next accept is the following cycle.
REQ-026 SHALL, on flush in BUSY or DONE, return to IDLE next cycle without rsp_valid; flush SHALL win over a simultaneous rsp handshake.
REQ-027 SHALL ignore flush in IDLE, and a request presented in the same cycle as flush SHALL be accepted.
REQ-028 SHALL drive rsp_result to zero when rsp_valid is low.
REQ-029 SHALL hold the cycle counter width at clog2(XLEN/BPC)+1 bits; the counter SHALL not wrap within an operation.

Reset
REQ-030 SHALL, while g_reset is high, force the FSM to IDLE, the accumulator, latched operands and counter to 0, req_ready=1, rsp_valid=0, and rsp_result=0.
REQ-031 SHALL discard an operation interrupted by reset with no response, and SHALL accept a new request on the first edge after reset deasserts.

Structure
REQ-032 SHALL place the pack-width codes, the FSM state encoding and the w-from-pw function in the shared scarv_cop package/include.
REQ-033 SHALL use one sub-module, scarv_cop_pmul_seg_acc: a combinational lane-segmented add/XOR of a partial product into the accumulator, controlled by pw and ncarry.

Verification
REQ-034 SHALL cover, with XLEN=32, BPC=1, w=32, a=b=0xFFFFFFFF: high=0 -> 0x00000001 and high=1 -> 0xFFFFFFFE, rsp_valid on the 33rd cycle after accept.
REQ-035 SHALL cover w=16, a=0x00030005, b=0x00070009, low -> 0x0015002D after 16 BUSY cycles.
REQ-036 SHALL cover w=8, ncarry=1, a=b=0x03030303, low -> 0x05050505; and w=4, a=b=0xFFFFFFFF, high -> 0xEEEEEEEE.
REQ-037 SHALL cover holding rsp_ready low for 5 cycles in DONE -> rsp_valid and rsp_result stable and req_ready=0, then one handshake -> IDLE.
REQ-038 SHALL cover flush on the 4th BUSY cycle -> IDLE next cycle with no rsp_valid, after which a new request completes correctly.
REQ-039 SHALL cover g_reset asserted mid-BUSY -> all outputs at reset values immediately, then a correct result after reset releases.

Source files
------------

// File: rtl/scarv_cop_pkg.sv
// Shared definitions for the SCARV coprocessor: pack-width codes, the packed
// multiplier FSM encoding and the lane-width helpers.
package scarv_cop_pkg;

    localparam logic [2:0] SCARV_COP_PW_1  = 3'b001;
    localparam logic [2:0] SCARV_COP_PW_2  = 3'b010;
    localparam logic [2:0] SCARV_COP_PW_4  = 3'b100;
    localparam logic [2:0] SCARV_COP_PW_8  = 3'b101;
    localparam logic [2:0] SCARV_COP_PW_16 = 3'b110;

    typedef enum logic [1:0] {
        PMUL_IDLE = 2'd0,
        PMUL_BUSY = 2'd1,
        PMUL_DONE = 2'd2
    } pmul_state_t;

    typedef struct packed {
        logic [2:0] pw;
        logic       high;
        logic       ncarry;
    } pmul_ctrl_t;

    // log2(XLEN / w); unknown codes fall back to a single full-width lane
    function automatic int pw_shift(input logic [2:0] pw);
        case (pw)
            SCARV_COP_PW_2:  return 1;
            SCARV_COP_PW_4:  return 2;
            SCARV_COP_PW_8:  return 3;
            SCARV_COP_PW_16: return 4;
            default:         return 0;
        endcase
    endfunction

    function automatic int lane_width(input logic [2:0] pw, input int xlen);
        return xlen >> pw_shift(pw);
    endfunction

endpackage

// File: rtl/scarv_cop_pmul_seg_acc.sv
// Lane-segmented accumulate: adds (or XORs) a partial product into the
// 2*XLEN accumulator with carries cut at every 2w-bit segment boundary.
module scarv_cop_pmul_seg_acc
    import scarv_cop_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2*XLEN-1:0] acc,
    input  logic [2*XLEN-1:0] pp,
    input  logic [2:0]        pw,
    input  logic              ncarry,
    output logic [2*XLEN-1:0] sum_c
);

    localparam int unsigned AW = 2 * XLEN;

    always_comb begin
        int   seg_m;
        logic carry;
        sum_c = '0;
        carry = 1'b0;
        seg_m = 2 * lane_width(pw, int'(XLEN)) - 1;
        for (int j = 0; j < int'(AW); j++) begin
            if ((j & seg_m) == 0) begin
                carry = 1'b0;
            end
            sum_c[j] = acc[j] ^ pp[j] ^ (carry & ~ncarry);
            carry    = (acc[j] & pp[j]) | (carry & (acc[j] ^ pp[j]));
        end
    end

endmodule

// File: rtl/scarv_cop_pmul_seq.sv
// Sequential packed (SIMD) multiplier: shift-and-add over w/BPC cycles with
// per-lane 2w-bit accumulator segments, optional carry-less mode.
module scarv_cop_pmul_seq
    import scarv_cop_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned BPC  = 1
) (
    input  logic            g_clk,
    input  logic            g_reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    input  logic [2:0]      req_pw,
    input  logic            req_high,
    input  logic            req_ncarry,
    input  logic            flush,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_result
);

    localparam int unsigned AW  = 2 * XLEN;
    localparam int unsigned XIW = $clog2(XLEN);
    localparam int unsigned AIW = $clog2(AW);
    localparam int unsigned CW  = $clog2(XLEN / BPC) + 1;

    pmul_state_t     state_q;
    pmul_ctrl_t      ctrl_q;
    logic [AW-1:0]   a_sh_q;
    logic [XLEN-1:0] b_sh_q;
    logic [AW-1:0]   acc_q;
    logic [CW-1:0]   cnt_q;

    logic [AW-1:0]   a_ext_c;
    logic [AW-1:0]   pp_c [BPC];
    logic [AW-1:0]   acc_mid_c;
    logic [AW-1:0]   acc_next_c;
    logic [XLEN-1:0] res_c;
    logic [CW-1:0]   busy_last_c;

    // Spread each w-bit lane of a into the low half of its 2w-bit segment
    always_comb begin
        int lw;
        int lane;
        int t;
        a_ext_c = '0;
        lane    = 0;
        t       = 0;
        lw      = int'(XIW) - pw_shift(req_pw);
        for (int j = 0; j < int'(AW); j++) begin
            lane = j >> (lw + 1);
            t    = j & ((1 << (lw + 1)) - 1);
            if (t < (1 << lw)) begin
                a_ext_c[j] = req_a[XIW'((lane << lw) + t)];
            end
        end
    end

    // Partial product for sub-bit s: shifted a gated by bit s of the lane's b
    always_comb begin
        int lw;
        int lane;
        int t;
        lane = 0;
        t    = 0;
        lw   = int'(XIW) - pw_shift(ctrl_q.pw);
        for (int s = 0; s < int'(BPC); s++) begin
            pp_c[s] = '0;
            for (int j = 0; j < int'(AW); j++) begin
                lane = j >> (lw + 1);
                t    = j & ((1 << (lw + 1)) - 1);
                if (t >= s) begin
                    pp_c[s][j] = a_sh_q[AIW'(j - s)] & b_sh_q[XIW'((lane << lw) + s)];
                end
            end
        end
    end

    scarv_cop_pmul_seg_acc #(
        .XLEN (XLEN)
    ) u_seg_acc0 (
        .acc    (acc_q),
        .pp     (pp_c[0]),
        .pw     (ctrl_q.pw),
        .ncarry (ctrl_q.ncarry),
        .sum_c  (acc_mid_c)
    );

    if (BPC > 1) begin : g_bpc2
        scarv_cop_pmul_seg_acc #(
            .XLEN (XLEN)
        ) u_seg_acc1 (
            .acc    (acc_mid_c),
            .pp     (pp_c[1]),
            .pw     (ctrl_q.pw),
            .ncarry (ctrl_q.ncarry),
            .sum_c  (acc_next_c)
        );
    end else begin : g_bpc1
        assign acc_next_c = acc_mid_c;
    end

    // Pick low or high w bits of each lane product and pack them back to XLEN
    always_comb begin
        int lw;
        int lane;
        int t;
        int src;
        res_c = '0;
        lane  = 0;
        t     = 0;
        src   = 0;
        lw    = int'(XIW) - pw_shift(ctrl_q.pw);
        for (int j = 0; j < int'(XLEN); j++) begin
            lane     = j >> lw;
            t        = j & ((1 << lw) - 1);
            src      = (lane << (lw + 1)) + t + (ctrl_q.high ? (1 << lw) : 0);
            res_c[j] = acc_next_c[AIW'(src)];
        end
        busy_last_c = CW'(((1 << lw) / int'(BPC)) - 1);
    end

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            state_q    <= PMUL_IDLE;
            ctrl_q     <= '0;
            a_sh_q     <= '0;
            b_sh_q     <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
        end else begin
            case (state_q)
                PMUL_IDLE: begin
                    if (req_valid && req_ready) begin
                        ctrl_q    <= '{pw: req_pw, high: req_high, ncarry: req_ncarry};
                        a_sh_q    <= a_ext_c;
                        b_sh_q    <= req_b;
                        acc_q     <= '0;
                        cnt_q     <= '0;
                        req_ready <= 1'b0;
                        state_q   <= PMUL_BUSY;
                    end
                end
                PMUL_BUSY: begin
                    if (flush) begin
                        req_ready <= 1'b1;
                        state_q   <= PMUL_IDLE;
                    end else begin
                        acc_q  <= acc_next_c;
                        a_sh_q <= a_sh_q << BPC;
                        b_sh_q <= b_sh_q >> BPC;
                        if (cnt_q == busy_last_c) begin
                            rsp_valid  <= 1'b1;
                            rsp_result <= res_c;
                            state_q    <= PMUL_DONE;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                PMUL_DONE: begin
                    // flush and a normal handshake both retire the result
                    if (flush || rsp_ready) begin
                        rsp_valid  <= 1'b0;
                        rsp_result <= '0;
                        req_ready  <= 1'b1;
                        state_q    <= PMUL_IDLE;
                    end
                end
                default: begin
                    rsp_valid  <= 1'b0;
                    rsp_result <= '0;
                    req_ready  <= 1'b1;
                    state_q    <= PMUL_IDLE;
                end
            endcase
        end
    end

endmodule
